// File: rtl/lap_timer_core.sv
// lap_timer_core: BCD stopwatch (mm:ss:cc) with start/stop, lap freeze and clear.
// Optional count-down/preload feature enabled by defining STOPWATCH_COUNTDOWN_EN;
// without it the core counts up only and expired stays 0.
module lap_timer_core #(
   parameter int unsigned DIV  = 10000,
   parameter int          WRAP = 1
) (
   input  logic        clk,
   input  logic        res,
   input  logic        start_stop,
   input  logic        lap,
   input  logic        clear,
   input  logic        mode_down,
   input  logic        load_valid,
   input  logic [23:0] load_time,
   output logic [23:0] time_bcd,
   output logic [23:0] disp_bcd,
   output logic        running,
   output logic        frozen,
   output logic        tick,
   output logic        expired
);

   localparam logic [15:0] DIV_M1  = 16'(DIV - 1);
   localparam logic [23:0] T_MAX   = 24'h595999;

   // Digit index 0 = ces_0X ... 5 = min_X0; tens of seconds/minutes roll at 5.
   function automatic logic [3:0] digit_max(input int idx);
      return (idx == 3 || idx == 5) ? 4'd5 : 4'd9;
   endfunction

   function automatic logic [23:0] bcd_inc(input logic [23:0] t);
      logic [23:0] r;
      logic        c;
      r = t;
      c = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (c) begin
            if (t[i*4 +: 4] >= digit_max(i)) begin
               r[i*4 +: 4] = 4'd0;
            end else begin
               r[i*4 +: 4] = t[i*4 +: 4] + 4'd1;
               c           = 1'b0;
            end
         end
      end
      return r;
   endfunction

   function automatic logic [23:0] bcd_dec(input logic [23:0] t);
      logic [23:0] r;
      logic        b;
      r = t;
      b = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (b) begin
            if (t[i*4 +: 4] == 4'd0) begin
               r[i*4 +: 4] = digit_max(i);
            end else begin
               r[i*4 +: 4] = t[i*4 +: 4] - 4'd1;
               b           = 1'b0;
            end
         end
      end
      return r;
   endfunction

   function automatic logic [23:0] bcd_clamp(input logic [23:0] t);
      logic [23:0] r;
      for (int i = 0; i < 6; i++) begin
         r[i*4 +: 4] = (t[i*4 +: 4] > digit_max(i)) ? digit_max(i) : t[i*4 +: 4];
      end
      return r;
   endfunction

   logic [23:0] r_time;
   logic [23:0] r_lap;
   logic [15:0] r_div;
   logic        r_running;
   logic        r_frozen;
   logic        r_tick;
   logic        r_expired;
   logic        r_ss_q;
   logic        r_lap_q;

   logic        w_ss_edge;
   logic        w_lap_edge;
   logic        w_div_wrap;
   logic        w_load;
   logic        w_down;
   logic [23:0] w_load_time;
   logic [23:0] w_time_inc;
   logic [23:0] w_time_dec;

`ifdef STOPWATCH_COUNTDOWN_EN
   assign w_load      = load_valid;
   assign w_down      = mode_down;
   assign w_load_time = bcd_clamp(load_time);
   assign expired     = r_expired;
`else
   logic w_unused_cfg;
   assign w_load       = 1'b0;
   assign w_down       = 1'b0;
   assign w_load_time  = 24'h000000;
   assign expired      = 1'b0;
   assign w_unused_cfg = ^{mode_down, load_valid, load_time, r_expired, bcd_clamp(load_time)};
`endif

   // Edge detection, divider terminal count and next-time candidates.
   always_comb begin
      w_ss_edge  = start_stop & ~r_ss_q;
      w_lap_edge = lap & ~r_lap_q;
      w_div_wrap = r_running && (r_div == DIV_M1);
      w_time_inc = bcd_inc(r_time);
      // Decrement saturates at zero so a tick at 00:00:00 holds.
      w_time_dec = (r_time == 24'h000000) ? 24'h000000 : bcd_dec(r_time);
   end

   // All stopwatch state; later assignments (overflow stop) override the run toggle.
   always_ff @(posedge clk) begin
      if (res) begin
         r_time    <= 24'h000000;
         r_lap     <= 24'h000000;
         r_div     <= 16'd0;
         r_running <= 1'b0;
         r_frozen  <= 1'b0;
         r_tick    <= 1'b0;
         r_expired <= 1'b0;
         r_ss_q    <= 1'b0;
         r_lap_q   <= 1'b0;
      end else begin
         r_ss_q  <= start_stop;
         r_lap_q <= lap;
         r_tick  <= 1'b0;
         if (w_ss_edge) r_running <= ~r_running;
         if (clear) begin
            r_time    <= 24'h000000;
            r_lap     <= 24'h000000;
            r_div     <= 16'd0;
            r_frozen  <= 1'b0;
            r_expired <= 1'b0;
         end else begin
            if (w_lap_edge) begin
               if (!r_frozen) begin
                  r_lap    <= r_time;
                  r_frozen <= 1'b1;
               end else begin
                  r_frozen <= 1'b0;
               end
            end
            if (w_load) begin
               r_time    <= w_load_time;
               r_expired <= 1'b0;
               r_div     <= 16'd0;
            end else if (w_div_wrap) begin
               r_div  <= 16'd0;
               r_tick <= 1'b1;
               if (w_down) begin
                  r_time <= w_time_dec;
                  if (w_time_dec == 24'h000000) begin
                     r_expired <= 1'b1;
                     r_running <= 1'b0;
                  end
               end else if (r_time == T_MAX && WRAP == 0) begin
                  r_running <= 1'b0;
               end else begin
                  r_time <= w_time_inc;
               end
            end else if (r_running) begin
               r_div <= r_div + 16'd1;
            end
         end
      end
   end

   assign time_bcd = r_time;
   assign disp_bcd = r_frozen ? r_lap : r_time;
   assign running  = r_running;
   assign frozen   = r_frozen;
   assign tick     = r_tick;

endmodule
